// File: rtl/regfile.sv
// regfile: register file with reg0 hard-wired to zero and ex/mem/wb read forwarding
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              ex_wreg_i,
    input  logic [ADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_wreg_i,
    input  logic [ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // youngest pending producer wins; register 0 and disabled/reset reads give zero
    function automatic logic [DATA_W-1:0] rd(input logic re, input logic [ADDR_W-1:0] a);
        return (rst || !re || a == '0)           ? '0 :
               (ex_wreg_i && ex_wd_i == a)       ? ex_wdata_i :
               (mem_wreg_i && mem_wd_i == a)     ? mem_wdata_i :
               (we && waddr == a)                ? wdata :
               (32'(a) < NREGS)                  ? regs_q[a] : '0;
    endfunction

    // write-back update; entry 0 and out-of-range addresses are never written
    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0 && 32'(waddr) < NREGS) regs_d[waddr] = wdata;
        regs_d[0] = '0;
    end

    // array register; reset clears everything and overrides any write
    always_ff @(posedge clk) begin
        if (rst) for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        else regs_q <= regs_d;
    end

    // both read ports answered combinationally with identical rules
    always_comb begin
        rdata1 = rd(re1, raddr1);
        rdata2 = rd(re2, raddr2);
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scenarios plus randomized regression against a behavioural model
module tb_regfile;

    logic        clk = 0;
    logic        rst, we, re1, re2, ex_wreg_i, mem_wreg_i;
    logic [4:0]  waddr, raddr1, raddr2, ex_wd_i, mem_wd_i;
    logic [31:0] wdata, ex_wdata_i, mem_wdata_i, rdata1, rdata2;
    logic [31:0] model [32];
    int          n_chk = 0, n_pass = 0;

    regfile dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst || !re || a == 0) return 0;
        if (ex_wreg_i && ex_wd_i == a) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
        if (we && waddr == a) return wdata;
        return model[a];
    endfunction

    task automatic idle();
        rst = 0; we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) for (int i = 0; i < 32; i++) model[i] = 0;
        else if (we && waddr != 0) model[waddr] = wdata;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle(); we = 1; waddr = a; wdata = d;
        cyc();
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 0;
        idle();
        @(negedge clk);
        rst = 1;
        cyc();
        re1 = 1; raddr1 = 7; ex_wreg_i = 1; ex_wd_i = 7; ex_wdata_i = 32'hDEAD; re2 = 1; raddr2 = 7;
        #1 chk("rst_rd1", rdata1, 0);
        chk("rst_rd2", rdata2, 0);
        cyc();
        idle(); re1 = 1; raddr1 = 7;
        #1 chk("r7_after_rst", rdata1, 0);
        we = 1; waddr = 7; wdata = 32'h1234_5678;
        #1 chk("r7_wthrough", rdata1, 32'h1234_5678);
        cyc();
        we = 0;
        #1 chk("r7_stored", rdata1, 32'h1234_5678);

        wr(0, 32'hFFFF_FFFF);
        re1 = 1; raddr1 = 0; ex_wreg_i = 1; ex_wd_i = 0; ex_wdata_i = 32'hFFFF_FFFF;
        mem_wreg_i = 1; mem_wd_i = 0; mem_wdata_i = 32'hFFFF_FFFF;
        #1 chk("r0_zero", rdata1, 0);

        wr(3, 32'h11);
        re1 = 1; raddr1 = 3;
        #1 chk("r3_old", rdata1, 32'h11);
        we = 1; waddr = 3; wdata = 32'h22;
        mem_wreg_i = 1; mem_wd_i = 3; mem_wdata_i = 32'h33;
        ex_wreg_i = 1; ex_wd_i = 3; ex_wdata_i = 32'h44;
        #1 chk("fwd_ex", rdata1, 32'h44);
        ex_wreg_i = 0;
        #1 chk("fwd_mem", rdata1, 32'h33);
        mem_wreg_i = 0;
        #1 chk("fwd_wb", rdata1, 32'h22);
        cyc();
        we = 0;
        #1 chk("r3_new", rdata1, 32'h22);

        wr(5, 32'hAB);
        re2 = 0; raddr2 = 5;
        #1 chk("re2_off", rdata2, 0);
        re2 = 1;
        #1 chk("re2_on", rdata2, 32'hAB);
        re1 = 1; raddr1 = 5;
        #1 chk("dual_rd1", rdata1, 32'hAB);
        chk("dual_rd2", rdata2, 32'hAB);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        for (int i = 0; i < 32; i++) begin
            re1 = 1; raddr1 = 5'(i); re2 = 1; raddr2 = 5'(31 - i);
            #1 chk("fill_rd1", rdata1, 32'(i));
            chk("fill_rd2", rdata2, 32'(31 - i));
        end
        idle(); rst = 1; we = 1; waddr = 9; wdata = 32'h99;
        cyc();
        idle();
        for (int i = 0; i < 32; i++) begin
            re1 = 1; raddr1 = 5'(i); re2 = 1; raddr2 = 5'(i);
            #1 chk("clr_rd1", rdata1, 0);
            chk("clr_rd2", rdata2, 0);
        end
        wr(9, 32'h5A);
        re1 = 1; raddr1 = 9;
        #1 chk("post_rst_wr", rdata1, 32'h5A);

        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            we = 1'($urandom); re1 = 1'($urandom | $urandom); re2 = 1'($urandom | $urandom);
            ex_wreg_i = 1'($urandom); mem_wreg_i = 1'($urandom);
            waddr  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            raddr1 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            raddr2 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            ex_wd_i  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            mem_wd_i = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            wdata = $urandom; ex_wdata_i = $urandom; mem_wdata_i = $urandom;
            #1 chk("rnd_rd1", rdata1, exp_rd(re1, raddr1));
            chk("rnd_rd2", rdata2, exp_rd(re2, raddr2));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
